serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  - Bit-serial WIDTH-bit subtractor: o = i1 - i2 - bin.
//  - Processes one bit per clock, LSB first, with a registered borrow.
//  - Companion to the combinational ripple-carry adder (the inverse operation).
//  - Trades latency for a single 1-bit full subtractor.
//  - Sits behind a start/done handshake in the lab datapath.
// PARAMETERS
//  - WIDTH  4  operand/result width in bits (>= 2)
// PORTS
//  - clk    in   1      system clock, rising edge
//  - rst    in   1      asynchronous, active-high reset
//  - start  in   1      request; sampled only in IDLE
//  - i1     in   WIDTH  minuend; latched on accepted start
//  - i2     in   WIDTH  subtrahend; latched on accepted start
//  - bin    in   1      borrow in; latched on accepted start
//  - busy   out  1      high while bits are being processed
//  - done   out  1      1-cycle pulse: result valid
//  - o      out  WIDTH  difference; held until the next accepted start
//  - bout   out  1      borrow out (1 when unsigned i1 < i2+bin)
//  - ovf    out  1      signed (two's complement) overflow
//  - zero   out  1      o == 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0; o=0, bout=0, ovf=0, zero=0;
//    operand/borrow/count registers cleared.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: start=1 at edge k latches i1, i2, bin; count=0; goes to SHIFT.
//  - SHIFT: busy=1. Each edge computes one bit from a[0], b[0], br:
//      d = a0^b0^br; br' = (~a0&b0) | (~(a0^b0)&br).
//    d shifts into the result MSB; a and b shift right; count++.
//  - SHIFT exit: at edge k+WIDTH (count reaches WIDTH) goes to DONE.
//    At that edge o, bout=br', ovf and zero update together.
//  - DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE.
//  - Latency: done is high in the cycle after edge k+WIDTH; new start accepted from edge k+WIDTH+2.
//  - start while SHIFT or DONE: ignored, with no effect on latched operands.
//  - Live operands: i1/i2/bin changes after acceptance do not affect the result.
//  - ovf = (a_msb != b_msb) && (o_msb != a_msb), using latched operand MSBs.
//    bin does not enter ovf except through o.
//  - Wrap-around: the result is modulo 2^WIDTH; bout reports the wrap.
//  - Reset mid-SHIFT aborts: outputs return to reset values; no done pulse.
//  - o/bout/ovf/zero are stable outside the update edge (no partial results visible).
// STRUCTURE
//  - Shared package/header: WIDTH default; state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
//  - Counter width: $clog2(WIDTH+1).
//  - Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational, one instance.
//  - Top holds the FSM, shift registers, borrow flop, counter and flag logic.
// TESTING
//  - Basic: i1=0101, i2=0011, bin=0, start -> after 4 SHIFT cycles done=1; o=0010, bout=0, ovf=0, zero=0.
//  - Borrow: i1=0010, i2=0101 -> o=1101, bout=1, ovf=0.
//  - Borrow in: i1=0000, i2=0000, bin=1 -> o=1111, bout=1; second run i1=i2=0110, bin=0 -> o=0000, zero=1.
//  - Overflow: i1=0111, i2=1000 -> o=1111, bout=1, ovf=1; i1=1000, i2=0001 -> o=0111, ovf=1, bout=0.
//  - Handshake: pulse start again mid-SHIFT with new operands -> ignored.
//    Exactly one done pulse at cycle k+WIDTH+1; busy=1 for exactly WIDTH cycles; o held until next start.
//  - Reset: assert rst during SHIFT cycle 2 -> busy=0, o=0 immediately (async), no done.
//    Then start i1=0111, i2=0110 -> o=0001, bout=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: d = a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor o = i1 - i2 - bin, LSB first, one bit per clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [WIDTH-1:0] a, b, res, res_n;
  logic [CW-1:0]    cnt;
  logic             br, amsb, bmsb;
  logic             d, br_n, last;

  full_subtractor u_fs (
    .a    (a[0]),
    .b    (b[0]),
    .bin  (br),
    .d    (d),
    .bout (br_n)
  );

  assign res_n = {d, res[WIDTH-1:1]};
  assign last  = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Flags are written only on the final shift so no partial result leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= '0;
      b    <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      o    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a    <= i1;
            b    <= i2;
            br   <= bin;
            res  <= '0;
            cnt  <= '0;
            amsb <= i1[WIDTH-1];
            bmsb <= i2[WIDTH-1];
          end
        end
        SHIFT: begin
          a   <= a >> 1;
          b   <= b >> 1;
          br  <= br_n;
          res <= res_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            o    <= res_n;
            bout <= br_n;
            ovf  <= (amsb != bmsb) && (d != amsb);
            zero <= (res_n == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] i1, i2, o;
  logic         busy, done, bout, ovf, zero;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .i1    (i1),
    .i2    (i2),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .o     (o),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output int eo, output int eb,
                       output int ev, output int ez);
    int u, s, sx, sy;
    u  = int'(x) - int'(y) - int'(c);
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = sx - sy - int'(c);
    eo = (u + (1 << W)) % (1 << W);
    eb = (u < 0) ? 1 : 0;
    ev = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
    ez = (eo == 0) ? 1 : 0;
  endtask

  task automatic run(input string tag, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic c);
    int eo, eb, ev, ez, nb, nd, at, ro, rb, rv, rz;
    model(x, y, c, eo, eb, ev, ez);
    nb = 0; nd = 0; at = -1;
    ro = 0; rb = 0; rv = 0; rz = 0;
    @(negedge clk);
    i1 = x; i2 = y; bin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        at = i;
        ro = int'(o); rb = int'(bout); rv = int'(ovf); rz = int'(zero);
      end
      i1  = W'($urandom);
      i2  = W'($urandom);
      bin = 1'($urandom);
      start = (i == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    chk({tag, ".o"},     ro, eo);
    chk({tag, ".bout"},  rb, eb);
    chk({tag, ".ovf"},   rv, ev);
    chk({tag, ".zero"},  rz, ez);
    chk({tag, ".busy"},  nb, W);
    chk({tag, ".ndone"}, nd, 1);
    chk({tag, ".doneat"}, at, W);
    chk({tag, ".held"},  int'(o), eo);
  endtask

  initial begin
    int eo, eb, ev, ez;
    rst = 1'b1; start = 1'b0; i1 = '0; i2 = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.o", int'(o), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.flags", int'({bout, ovf, zero}), 0);
    rst = 1'b0;

    run("basic",  4'b0101, 4'b0011, 1'b0);
    run("borrow", 4'b0010, 4'b0101, 1'b0);
    run("binf",   4'b0000, 4'b0000, 1'b1);
    run("zero",   4'b0110, 4'b0110, 1'b0);
    run("ovfp",   4'b0111, 4'b1000, 1'b0);
    run("ovfn",   4'b1000, 4'b0001, 1'b0);
    run("ovfb",   4'b1000, 4'b0000, 1'b1);

    // Abort during the second shift cycle.
    @(negedge clk);
    i1 = 4'b0101; i2 = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.o", int'(o), 0);
    chk("abort.flags", int'({bout, ovf, zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < W + 3; i++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("abort.nodone", nd, 0);
    end
    run("after", 4'b0111, 4'b0110, 1'b0);

    for (int k = 0; k < 20; k++)
      run("rand", W'($urandom), W'($urandom), 1'($urandom));

    model(4'b0101, 4'b0011, 1'b0, eo, eb, ev, ez);
    chk("model.sanity", eo, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
